// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes and registered results/flags.
// Shifts run one bit per cycle; MUL is an iterative shift-add.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [3:0]       operator,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             c_flag,
   output logic             z_flag,
   output logic             s_flag,
   output logic             ov_flag,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int M = WIDTH - 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_LSL = 4'd6;
   localparam logic [3:0] OP_LSR = 4'd7;
   localparam logic [3:0] OP_ADC = 4'd8;
   localparam logic [3:0] OP_MUL = 4'd9;
   localparam logic [3:0] OP_ASR = 4'd10;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [3:0]         r_op;
   logic [WIDTH-1:0]   r_sh;
   logic [WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0] r_prod;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_cf;
   logic [WIDTH-1:0]   r_res;
   logic               r_c;
   logic               r_z;
   logic               r_s;
   logic               r_ov;

   logic               w_accept;
   logic               w_is_shift;
   logic               w_multi;
   logic [CNT_W-1:0]   w_amt;
   logic               w_last;
   logic               w_load;
   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_adc;
   logic [WIDTH:0]     w_sub;
   logic [WIDTH-1:0]   w_one_res;
   logic               w_one_c;
   logic               w_one_ov;
   logic [WIDTH-1:0]   w_sh_next;
   logic               w_sh_c;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_prod_next;
   logic [WIDTH-1:0]   w_ex_res;
   logic               w_ex_c;
   logic               w_ex_ov;
   logic [3:0]         w_fin_op;
   logic [WIDTH-1:0]   w_fin_res;
   logic               w_fin_c;
   logic               w_fin_ov;
   logic               w_cf_upd;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign res       = r_res;
   assign c_flag    = r_c;
   assign z_flag    = r_z;
   assign s_flag    = r_s;
   assign ov_flag   = r_ov;

   assign w_accept   = in_valid && (r_state == S_IDLE);
   assign w_is_shift = (operator == OP_LSL) || (operator == OP_LSR)
                    || (operator == OP_ASR);
   assign w_amt      = (op2 >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH)
                                             : op2[CNT_W-1:0];
   assign w_multi    = (operator == OP_MUL)
                    || (w_is_shift && (w_amt != '0));
   assign w_last     = (r_state == S_EXEC) && (r_cnt == CNT_W'(1));
   assign w_load     = (w_accept && !w_multi) || w_last;

   assign w_add = {1'b0, op1} + {1'b0, op2};
   assign w_adc = w_add + {{WIDTH{1'b0}}, r_cf};
   assign w_sub = {1'b0, op1} - {1'b0, op2};

   always_comb begin
      w_one_res = '0;
      w_one_c   = 1'b0;
      w_one_ov  = 1'b0;
      case (operator)
         OP_ADD: begin
            w_one_res = w_add[M:0];
            w_one_c   = w_add[WIDTH];
            w_one_ov  = (op1[M] == op2[M]) && (w_add[M] != op1[M]);
         end
         OP_SUB: begin
            w_one_res = w_sub[M:0];
            w_one_c   = w_sub[WIDTH];
            w_one_ov  = (op1[M] != op2[M]) && (w_sub[M] != op1[M]);
         end
         OP_ADC: begin
            w_one_res = w_adc[M:0];
            w_one_c   = w_adc[WIDTH];
            w_one_ov  = (op1[M] == op2[M]) && (w_adc[M] != op1[M]);
         end
         OP_AND: w_one_res = op1 & op2;
         OP_OR:  w_one_res = op1 | op2;
         OP_XOR: w_one_res = op1 ^ op2;
         OP_NOT: w_one_res = ~op1;
         // zero-amount shifts finish here unchanged
         OP_LSL, OP_LSR, OP_ASR: w_one_res = op1;
         default: w_one_res = '0;
      endcase
   end

   always_comb begin
      w_sh_next = r_sh;
      w_sh_c    = 1'b0;
      case (r_op)
         OP_LSL: begin
            w_sh_next = {r_sh[M-1:0], 1'b0};
            w_sh_c    = r_sh[M];
         end
         OP_LSR: begin
            w_sh_next = {1'b0, r_sh[M:1]};
            w_sh_c    = r_sh[0];
         end
         OP_ASR: begin
            w_sh_next = {r_sh[M], r_sh[M:1]};
            w_sh_c    = r_sh[0];
         end
         default: ;
      endcase
   end

   assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                      + (r_prod[0] ? {1'b0, r_mcand} : '0);
   assign w_prod_next = {w_mul_sum, r_prod[M:1]};

   always_comb begin
      w_ex_res = w_sh_next;
      w_ex_c   = w_sh_c;
      w_ex_ov  = 1'b0;
      if (r_op == OP_MUL) begin
         w_ex_res = w_prod_next[M:0];
         w_ex_c   = |w_prod_next[2*WIDTH-1:WIDTH];
         w_ex_ov  = w_ex_c;
      end
   end

   assign w_fin_op  = (r_state == S_EXEC) ? r_op : operator;
   assign w_fin_res = (r_state == S_EXEC) ? w_ex_res : w_one_res;
   assign w_fin_c   = (r_state == S_EXEC) ? w_ex_c : w_one_c;
   assign w_fin_ov  = (r_state == S_EXEC) ? w_ex_ov : w_one_ov;
   assign w_cf_upd  = (w_fin_op == OP_ADD) || (w_fin_op == OP_SUB)
                   || (w_fin_op == OP_ADC) || (w_fin_op == OP_LSL)
                   || (w_fin_op == OP_LSR) || (w_fin_op == OP_ASR);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (in_valid) w_next = w_multi ? S_EXEC : S_DONE;
         S_EXEC: if (w_last) w_next = S_DONE;
         S_DONE: if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op    <= '0;
         r_sh    <= '0;
         r_mcand <= '0;
         r_prod  <= '0;
         r_cnt   <= '0;
         r_cf    <= 1'b0;
         r_res   <= '0;
         r_c     <= 1'b0;
         r_z     <= 1'b0;
         r_s     <= 1'b0;
         r_ov    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op    <= operator;
            r_sh    <= op1;
            r_mcand <= op1;
            r_prod  <= {{WIDTH{1'b0}}, op2};
            r_cnt   <= (operator == OP_MUL) ? CNT_W'(WIDTH) : w_amt;
         end else if (r_state == S_EXEC) begin
            r_sh   <= w_sh_next;
            r_prod <= w_prod_next;
            r_cnt  <= r_cnt - CNT_W'(1);
         end
         if (w_load) begin
            r_res <= w_fin_res;
            r_c   <= w_fin_c;
            r_z   <= (w_fin_res == '0);
            r_s   <= w_fin_res[M];
            r_ov  <= w_fin_ov;
            if (w_cf_upd) r_cf <= w_fin_c;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_seq;

   localparam int W = 8;
   localparam int MASK = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] op1 = '0;
   logic [W-1:0] op2 = '0;
   logic [3:0]   operator = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] res;
   logic         c_flag, z_flag, s_flag, ov_flag, busy;

   int n_tests = 0;
   int n_fail  = 0;
   int m_cf    = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op1(op1), .op2(op2), .operator(operator),
      .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .c_flag(c_flag), .z_flag(z_flag),
      .s_flag(s_flag), .ov_flag(ov_flag), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int res; int c; int ov; int lat; int cfu;
   } exp_t;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sx(input int v);
      return (v >= 128) ? v - 256 : v;
   endfunction

   function automatic exp_t model(input int op, input int a, input int b,
                                  input int cf);
      exp_t e;
      int amt, s;
      e = '{0, 0, 0, 1, 0};
      amt = (b > W) ? W : b;
      case (op)
         0: begin
            s = a + b; e.res = s & MASK; e.c = int'(s > MASK);
            s = sx(a) + sx(b); e.ov = int'(s > 127 || s < -128);
            e.cfu = 1;
         end
         1: begin
            e.res = (a - b) & MASK; e.c = int'(a < b);
            s = sx(a) - sx(b); e.ov = int'(s > 127 || s < -128);
            e.cfu = 1;
         end
         2: e.res = a & b;
         3: e.res = a | b;
         4: e.res = a ^ b;
         5: e.res = (~a) & MASK;
         6: begin
            e.res = (a << amt) & MASK;
            e.c = (amt == 0) ? 0 : (a >> (W - amt)) & 1;
            e.lat = 1 + amt; e.cfu = 1;
         end
         7: begin
            e.res = a >> amt;
            e.c = (amt == 0) ? 0 : (a >> (amt - 1)) & 1;
            e.lat = 1 + amt; e.cfu = 1;
         end
         8: begin
            s = a + b + cf; e.res = s & MASK; e.c = int'(s > MASK);
            s = sx(a) + sx(b) + cf; e.ov = int'(s > 127 || s < -128);
            e.cfu = 1;
         end
         9: begin
            s = a * b; e.res = s & MASK;
            e.c = int'((s >> W) != 0); e.ov = e.c; e.lat = 1 + W;
         end
         10: begin
            e.res = (sx(a) >>> amt) & MASK;
            e.c = (amt == 0) ? 0 : (sx(a) >>> (amt - 1)) & 1;
            e.lat = 1 + amt; e.cfu = 1;
         end
         default: e.res = 0;
      endcase
      return e;
   endfunction

   task automatic do_op(input int op, input int a, input int b,
                        input int hold);
      exp_t e;
      int lat;
      e = model(op, a, b, m_cf);
      @(negedge clk);
      check("in_ready_idle", 32'(in_ready), 32'd1);
      operator = 4'(op); op1 = W'(a); op2 = W'(b); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("lat op%0d", op), 32'(lat), 32'(e.lat));
      check($sformatf("res op%0d", op), 32'(res), 32'(e.res));
      check("c", 32'(c_flag), 32'(e.c));
      check("ov", 32'(ov_flag), 32'(e.ov));
      check("z", 32'(z_flag), 32'(e.res == 0));
      check("s", 32'(s_flag), 32'((e.res >> (W - 1)) & 1));
      check("busy_done", 32'(busy), 32'd1);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'b1; operator = 4'd0; op1 = W'($urandom);
         @(posedge clk); #1;
         in_valid = 1'b0;
         check("hold_res", 32'(res), 32'(e.res));
         check("hold_c", 32'(c_flag), 32'(e.c));
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("rel_out_valid", 32'(out_valid), 32'd0);
      check("rel_in_ready", 32'(in_ready), 32'd1);
      if (e.cfu != 0) m_cf = e.c;
   endtask

   initial begin
      int op, a, b;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_res", 32'(res), 32'd0);
      check("rst_flags", 32'({c_flag, z_flag, s_flag, ov_flag}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op(0, 127, 1, 0);
      do_op(1, 5, 10, 0);
      do_op(8, 255, 0, 0);
      do_op(9, 16, 17, 0);
      do_op(9, 12, 10, 0);
      do_op(6, 'h81, 3, 0);
      do_op(7, 'h81, 1, 0);
      do_op(10, 'h80, 9, 0);
      do_op(6, 'h5A, 0, 0);
      do_op(3, 'h0F, 'hF0, 5);
      do_op(1, 0, 1, 0);

      // abort a MUL mid-flight while the stored carry is set
      @(negedge clk);
      operator = 4'd9; op1 = 8'd200; op2 = 8'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_cf = 0;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      do_op(8, 1, 1, 0);
      do_op(12, 'h33, 'h44, 0);

      for (int k = 0; k < 60; k++) begin
         op = int'($urandom_range(0, 15));
         a  = int'($urandom_range(0, MASK));
         b  = (op == 6 || op == 7 || op == 10)
              ? int'($urandom_range(0, 10))
              : int'($urandom_range(0, MASK));
         do_op(op, a, b, int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
